hamming_serial_rx: RTL and testbench
====================================

// Module: hamming_serial_rx
// PURPOSE
//  Downstream consumer of the Hamming-protected universal register's serial output.
//  - Deserialises 13-bit SECDED codewords, LSB first.
//  - Corrects single-bit errors and flags double-bit errors.
//  - Buffers decoded bytes in a small FIFO with a valid/ready output.
//  - Keeps saturating error and drop statistics for the register test environment.
// PARAMETERS
//  FIFO_DEPTH  4  output FIFO entries; power of 2, >=2
//  CNT_W       8  width of each saturating statistics counter
// PORTS
//  clk            in   1      single clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  bit_valid      in   1      bit_in/sof are valid this cycle
//  bit_in         in   1      serial codeword bit, LSB (cw[0]) first
//  sof            in   1      qualifies bit_in as cw[0] of a new frame
//  out_valid      out  1      FIFO head available
//  out_ready      in   1      consumer accepts head this cycle
//  out_data       out  8      decoded/corrected byte at FIFO head
//  out_corrected  out  1      head byte had a single error, now fixed
//  out_uncorr     out  1      head byte had a double/invalid error; data is raw
//  busy           out  1      frame in progress (state != IDLE)
//  clr_stats      in   1      synchronous clear of all counters
//  corr_cnt       out  CNT_W  corrected frames, saturating
//  uncorr_cnt     out  CNT_W  uncorrectable frames, saturating
//  drop_cnt       out  CNT_W  frames lost to FIFO full or aborted by sof, saturating
// BEHAVIOUR
//  Codeword layout
//  - cw[i], i=1..12, is Hamming position i. Parity bits sit at positions 1, 2, 4, 8.
//  - Data bits d0..d7 sit at positions 3, 5, 6, 7, 9, 10, 11, 12.
//  - cw[0] is overall parity: the XOR of all 13 bits is 0 for a clean word.
//  Reset
//  - All outputs are 0. FIFO is empty, FSM is in IDLE, counters are 0, any partial frame is discarded.
//  - Reset mid-frame or mid-FIFO drops everything.
//  FSM states
//  - IDLE: bit_valid&&sof captures cw[0], bit index=1, go to SHIFT.
//    - bit_valid without sof is ignored.
//  - SHIFT: each bit_valid stores bit_in at the index and increments it.
//    - Gaps in bit_valid are allowed.
//    - When cw[12] is captured, go to DECODE.
//    - sof with bit_valid in SHIFT aborts the frame: drop_cnt++, the bit becomes cw[0] of a new frame, index=1, stay in SHIFT.
//  - DECODE: one cycle, bits ignored. Decode s = syndrome (4 bits) and q = XOR over all 13 bits.
//    - q=0, s=0: clean.
//    - q=1, s=0: error in cw[0]; data intact; corrected=1.
//    - q=1, s in 1..12: flip cw[s]; corrected=1.
//    - q=1, s in 13..15: uncorr=1.
//    - q=0, s!=0: double error; uncorr=1.
//    - Uncorrectable frames pass the raw data bits through.
//    - Push {data,corrected,uncorr} to the FIFO on the DECODE clock edge, then go to IDLE.
//    - Counters update on that same edge.
//  Latency
//  - 13th bit captured at edge E. DECODE occupies the cycle after E. FIFO write at edge E+1.
//  - out_valid is high after E+1 if the FIFO was empty. The next sof is accepted from the cycle after E+1.
//  Handshake
//  - Pop on out_valid&&out_ready.
//  - out_* are stable while out_valid && !out_ready.
//  - out_valid never deasserts without a pop.
//  FIFO boundaries
//  - Push when full: allowed if a pop occurs the same cycle; otherwise drop and drop_cnt++.
//  - Push when empty: visible the next cycle; no bypass.
//  - Pointers wrap mod FIFO_DEPTH, with an extra bit for the full/empty distinction.
//  Counters
//  - Saturate at all-ones.
//  - clr_stats wins over a same-cycle increment.
// STRUCTURE
//  - hamming_pkg:
//    - CW_W=13
//    - typedef logic [12:0] codeword_t
//    - data-position constants
//    - functions hamming_encode(byte) and hamming_syndrome(cw), shared with benches
//  - Sub-module hamming_secded_dec: combinational cw -> {data, corrected, uncorr}.
//  - The top holds the FSM, shift register, FIFO and counters.
// TESTING
//  1. Reset with rst=1, all inputs toggling -> all outputs 0, busy=0.
//  2. Clean frame 0x144E -> out_data=0xA5, flags 0, out_valid one edge after the 13th bit.
//  3. Single error 0x140E (pos 6 flipped) -> 0xA5, corrected=1, corr_cnt=1.
//     Single error 0x144F (cw[0] flipped) -> 0xA5, corrected=1, corr_cnt=2.
//  4. Double error 0x1046 (pos 3 and 10 flipped) -> out_data=0x84 raw, uncorr=1, uncorr_cnt=1.
//  5. out_ready=0, five clean frames -> four buffered in order, drop_cnt=1.
//     Then out_ready=1 -> four pops, then out_valid=0.
//  6. sof at bit 7, then a full 0x144E -> drop_cnt++, output 0xA5.
//     rst asserted at bit 5 -> nothing output, busy=0.
//     Also: gapped bit_valid; clr_stats while incrementing -> counter reads 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared types, codeword layout and Hamming(12,8)+parity helpers
package hamming_pkg;

    localparam int CW_W = 13;

    typedef logic [CW_W-1:0] codeword_t;

    localparam int DATA_POS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DECODE
    } rx_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       corrected;
        logic       uncorr;
    } rx_entry_t;

    function automatic logic [3:0] hamming_syndrome(input codeword_t cw);
        logic [3:0] s;
        s = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (cw[i]) s = s ^ 4'(i);
        end
        return s;
    endfunction

    // With parity positions zero, the syndrome bits are exactly the parity bits needed.
    function automatic codeword_t hamming_encode(input logic [7:0] d);
        codeword_t  cw;
        logic [3:0] s;
        cw = '0;
        for (int k = 0; k < 8; k++) begin
            cw[DATA_POS[k]] = d[k];
        end
        s = hamming_syndrome(cw);
        cw[1] = s[0];
        cw[2] = s[1];
        cw[4] = s[2];
        cw[8] = s[3];
        cw[0] = ^cw[CW_W-1:1];
        return cw;
    endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// rtl/hamming_secded_dec.sv - combinational SECDED decode of one 13-bit codeword
module hamming_secded_dec
    import hamming_pkg::*;
(
    input  codeword_t  cw,
    output logic [7:0] data,
    output logic       corrected,
    output logic       uncorr
);

    logic [3:0] syn;
    logic       q;
    codeword_t  fixed;

    always_comb begin
        syn       = hamming_syndrome(cw);
        q         = ^cw;
        fixed     = cw;
        corrected = 1'b0;
        uncorr    = 1'b0;
        if (q) begin
            if (syn == 4'd0) begin
                corrected = 1'b1;
            end else if (syn <= 4'd12) begin
                fixed[syn] = ~cw[syn];
                corrected  = 1'b1;
            end else begin
                uncorr = 1'b1;
            end
        end else if (syn != 4'd0) begin
            uncorr = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            data[k] = fixed[DATA_POS[k]];
        end
    end

endmodule

// File: rtl/hamming_serial_rx.sv
// rtl/hamming_serial_rx.sv - serial SECDED receiver with output FIFO and saturating statistics
module hamming_serial_rx
    import hamming_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_corrected,
    output logic             out_uncorr,
    output logic             busy,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    rx_state_t  state;
    codeword_t  sr;
    logic [3:0] idx;

    logic [7:0] dec_data;
    logic       dec_corr;
    logic       dec_uncorr;

    hamming_secded_dec u_dec (
        .cw        (sr),
        .data      (dec_data),
        .corrected (dec_corr),
        .uncorr    (dec_uncorr)
    );

    rx_entry_t   mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push, pop, push_ok, abort, fifo_drop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = out_valid && out_ready;
    assign push      = (state == S_DECODE);
    assign push_ok   = push && (!full || pop);
    assign fifo_drop = push && full && !pop;
    assign abort     = (state == S_SHIFT) && bit_valid && sof;

    assign out_valid     = !empty;
    assign out_data      = mem[rd_ptr[AW-1:0]].data;
    assign out_corrected = mem[rd_ptr[AW-1:0]].corrected;
    assign out_uncorr    = mem[rd_ptr[AW-1:0]].uncorr;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            sr    <= '0;
            idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bit_valid && sof) begin
                        sr    <= {12'b0, bit_in};
                        idx   <= 4'd1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_valid && sof) begin
                        sr  <= {12'b0, bit_in};
                        idx <= 4'd1;
                    end else if (bit_valid) begin
                        sr[idx] <= bit_in;
                        idx     <= idx + 4'd1;
                        if (idx == 4'd12) state <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= '{data: dec_data, corrected: dec_corr, uncorr: dec_uncorr};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Counters track every decoded frame, even ones the full FIFO then drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            drop_cnt   <= '0;
        end else if (clr_stats) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (push && dec_corr && corr_cnt != '1)     corr_cnt   <= corr_cnt + 1'b1;
            if (push && dec_uncorr && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
            if ((abort || fifo_drop) && drop_cnt != '1) drop_cnt   <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// tb/tb_hamming_serial_rx.sv - directed self-checking bench for hamming_serial_rx
module tb_hamming_serial_rx;
    import hamming_pkg::*;

    logic       clk = 1'b0;
    logic       rst, bit_valid, bit_in, sof, out_ready, clr_stats;
    logic       out_valid, out_corrected, out_uncorr, busy;
    logic [7:0] out_data, corr_cnt, uncorr_cnt, drop_cnt;

    int errors = 0;
    int checks = 0;

    hamming_serial_rx #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .bit_valid     (bit_valid),
        .bit_in        (bit_in),
        .sof           (sof),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_corrected (out_corrected),
        .out_uncorr    (out_uncorr),
        .busy          (busy),
        .clr_stats     (clr_stats),
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] cw;
        logic [7:0]  data;
        logic        corr;
        logic        unc;
        logic [7:0]  ccnt;
        logic [7:0]  ucnt;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        bit_valid = 1'b1;
        bit_in    = b;
        sof       = s;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        sof       = 1'b0;
    endtask

    // Returns in the DECODE cycle, one cycle after the 13th bit edge.
    task automatic send_frame(input logic [12:0] cw, input int gap);
        for (int i = 0; i < 13; i++) begin
            send_bit(cw[i], i == 0);
            if (gap > 0 && i < 12) repeat (gap) tick();
        end
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [12:0] part;

        vecs[0] = '{13'h144E, 8'hA5, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[1] = '{13'h140E, 8'hA5, 1'b1, 1'b0, 8'd1, 8'd0};
        vecs[2] = '{13'h144F, 8'hA5, 1'b1, 1'b0, 8'd2, 8'd0};
        vecs[3] = '{13'h1046, 8'h84, 1'b0, 1'b1, 8'd2, 8'd1};
        vecs[4] = '{13'h0000, 8'h00, 1'b0, 1'b0, 8'd2, 8'd1};
        vecs[5] = '{13'h044E, 8'hA5, 1'b1, 1'b0, 8'd3, 8'd1};
        vecs[6] = '{13'h0448, 8'h25, 1'b0, 1'b1, 8'd3, 8'd2};

        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; sof = 1'b0;
        out_ready = 1'b0; clr_stats = 1'b0;

        for (int c = 0; c < 4; c++) begin
            bit_valid = 1'($urandom); bit_in = 1'($urandom); sof = 1'($urandom);
            out_ready = 1'($urandom); clr_stats = 1'($urandom);
            tick();
            chk("reset_outputs", {out_valid, out_data, out_corrected, out_uncorr, busy}, 0);
            chk("reset_counters", {corr_cnt, uncorr_cnt, drop_cnt}, 0);
        end
        bit_valid = 1'b0; bit_in = 1'b0; sof = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
        rst = 1'b0;
        tick();

        part = hamming_encode(8'hA5);
        chk("pkg_encode_a5", int'(part), 32'h144E);

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].cw, 0);
            chk($sformatf("v%0d_decode_cycle_valid", v), out_valid, 0);
            chk($sformatf("v%0d_decode_cycle_busy", v), busy, 1);
            tick();
            chk($sformatf("v%0d_valid", v), out_valid, 1);
            chk($sformatf("v%0d_data", v), out_data, vecs[v].data);
            chk($sformatf("v%0d_flags", v), {out_corrected, out_uncorr}, {vecs[v].corr, vecs[v].unc});
            chk($sformatf("v%0d_corr_cnt", v), corr_cnt, vecs[v].ccnt);
            chk($sformatf("v%0d_uncorr_cnt", v), uncorr_cnt, vecs[v].ucnt);
            chk($sformatf("v%0d_busy_idle", v), busy, 0);
            pop_one();
            chk($sformatf("v%0d_empty_after_pop", v), out_valid, 0);
        end

        for (int k = 1; k <= 5; k++) begin
            send_frame(hamming_encode(8'(8'h11 * k)), 0);
            tick();
            chk($sformatf("full_head_stable_%0d", k), out_data, 8'h11);
        end
        chk("full_drop_cnt", drop_cnt, 1);
        chk("full_corr_cnt", corr_cnt, 3);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain_valid_%0d", k), out_valid, 1);
            chk($sformatf("drain_data_%0d", k), out_data, 8'(8'h11 * k));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 0);

        part = 13'h144E;
        for (int i = 0; i < 7; i++) send_bit(part[i], i == 0);
        chk("abort_busy", busy, 1);
        send_frame(13'h144E, 2);
        chk("abort_drop_cnt", drop_cnt, 2);
        tick();
        chk("abort_valid", out_valid, 1);
        chk("abort_data", out_data, 8'hA5);
        chk("abort_flags", {out_corrected, out_uncorr}, 0);
        pop_one();
        chk("abort_single_output", out_valid, 0);

        send_frame(13'h140E, 0);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_corr_cnt", corr_cnt, 0);
        chk("clr_other_cnt", {uncorr_cnt, drop_cnt}, 0);
        chk("clr_frame_data", out_data, 8'hA5);
        chk("clr_frame_corr", out_corrected, 1);
        pop_one();

        part = 13'h144E;
        for (int i = 0; i < 5; i++) send_bit(part[i], i == 0);
        chk("midreset_busy_before", busy, 1);
        rst = 1'b1;
        #2;
        chk("midreset_busy_async", busy, 0);
        tick();
        rst = 1'b0;
        for (int i = 5; i < 13; i++) send_bit(part[i], 1'b0);
        tick();
        tick();
        chk("midreset_no_output", out_valid, 0);
        chk("midreset_busy_after", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
